// File: rtl/ps2_rx_event_fifo.sv
// PS/2 receiver: glitch filter, 11-bit frame FSM, E0/F0 prefix folding and a show-ahead event FIFO.
// Optional receive watchdog is built only when PS2_TIMEOUT_EN is defined.
module ps2_rx_event_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic                          clk25,
  input  logic                          clr_n,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [9:0]                    dout,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] c_sh_q, d_sh_q;
  logic                  c_f_q, d_f_q, c_fp_q;
  logic                  fall;

  always_ff @(posedge clk25) begin
    if (!clr_n) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_sh_q   <= '1;
      d_sh_q   <= '1;
      c_f_q    <= 1'b1;
      d_f_q    <= 1'b1;
      c_fp_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      c_sh_q   <= {c_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
      d_sh_q   <= {d_sh_q[FILTER_LEN-2:0], d_sync_q[1]};
      // a line only changes once the whole window agrees
      if (&c_sh_q)       c_f_q <= 1'b1;
      else if (~|c_sh_q) c_f_q <= 1'b0;
      if (&d_sh_q)       d_f_q <= 1'b1;
      else if (~|d_sh_q) d_f_q <= 1'b0;
      c_fp_q <= c_f_q;
    end
  end

  assign fall = c_fp_q & ~c_f_q;

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] byte_q;
  logic       par_q, byte_ok_q, err_p_q;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q;
`else
  // the watchdog limit only matters when the watchdog is built
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk25) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      byte_ok_q <= 1'b0;
      err_p_q   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      byte_ok_q <= 1'b0;
      err_p_q   <= 1'b0;
      if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!d_f_q) begin
              state_q  <= S_DATA;
              bitcnt_q <= '0;
            end
          end
          S_DATA: begin
            byte_q   <= {d_f_q, byte_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= d_f_q;
            state_q <= S_STOP;
          end
          default: begin
            if (d_f_q && (^{byte_q, par_q})) byte_ok_q <= 1'b1;
            else                             err_p_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      if (state_q == S_IDLE || fall) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + 1'b1;
      if (!fall && state_q != S_IDLE && to_cnt_q == TO_MAX) begin
        state_q <= S_IDLE;
        err_p_q <= 1'b1;
      end
`endif
    end
  end

  logic           ext_p_q, brk_p_q, overflow_q, frame_err_q;
  logic           push_req, push, pop, full, ovf_set;
  logic [9:0]     din, dout_q, dout_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [9:0]     mem_q [FIFO_DEPTH];

  assign push_req = byte_ok_q && (byte_q != 8'hF0) && (byte_q != 8'hE0);
  assign din      = {ext_p_q, brk_p_q, byte_q};
  assign full     = (cnt_q == FULL_CNT);
  assign pop      = rd_en && (cnt_q != '0);
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign rd_next  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    dout_d = dout_q;
    // bypass the incoming word when it lands in the new head slot
    if (cnt_d != '0) dout_d = (push && rd_next == wr_ptr_q) ? din : mem_q[rd_next];
  end

  always_ff @(posedge clk25) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk25) begin
    if (!clr_n) begin
      ext_p_q     <= 1'b0;
      brk_p_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (err_p_q) begin
        ext_p_q <= 1'b0;
        brk_p_q <= 1'b0;
      end else if (byte_ok_q) begin
        if (byte_q == 8'hF0)      brk_p_q <= 1'b1;
        else if (byte_q == 8'hE0) ext_p_q <= 1'b1;
        else begin
          ext_p_q <= 1'b0;
          brk_p_q <= 1'b0;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q    <= rd_next;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      overflow_q  <= ovf_set | (overflow_q & ~err_clr);
      frame_err_q <= err_p_q | (frame_err_q & ~err_clr);
    end
  end

  assign dout      = dout_q;
  assign valid     = (cnt_q != '0);
  assign count     = cnt_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
